// File: rtl/booth_pp_gen.sv
// Radix-4 Booth recoder / partial-product generator, signed 16x16.
// Encodes DPC digits per clock and holds P0..P7 for the summation tree.
module booth_pp_gen #(
    parameter int DPC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [17:0] P0,
    output logic [17:0] P1,
    output logic [17:0] P2,
    output logic [17:0] P3,
    output logic [17:0] P4,
    output logic [17:0] P5,
    output logic [17:0] P6,
    output logic [17:0] P7
);

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        DONE
    } state_t;

    // Counter wraps to 0 when DPC=8, so the step is taken modulo 8.
    localparam logic [2:0] STEP = 3'(DPC);
    localparam logic [2:0] LAST = 3'(8 - DPC);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt;
    logic [17:0] a_q;
    logic [16:0] bx_q;
    logic [17:0] p_q [8];
    logic [2:0]  idx [DPC];
    logic [17:0] pp  [DPC];

    function automatic logic [17:0] booth(
        input logic [2:0]  t,
        input logic [17:0] a
    );
        logic [17:0] r;
        unique case (t)
            3'b001, 3'b010: r = a;
            3'b011:         r = a << 1;
            3'b100:         r = ~(a << 1) + 18'd1;
            3'b101, 3'b110: r = ~a + 18'd1;
            default:        r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        for (int j = 0; j < DPC; j++) begin
            idx[j] = cnt + 3'(j);
            pp[j]  = booth(bx_q[{1'b0, idx[j], 1'b0} +: 3], a_q);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = ENC;
            ENC:     if (cnt == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            bx_q    <= '0;
            for (int i = 0; i < 8; i++) p_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                a_q  <= {{2{A[15]}}, A};
                bx_q <= {B, 1'b0};
                cnt  <= '0;
            end
            if (state_q == ENC) begin
                for (int j = 0; j < DPC; j++) p_q[idx[j]] <= pp[j];
                cnt <= cnt + STEP;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    assign P0 = p_q[0];
    assign P1 = p_q[1];
    assign P2 = p_q[2];
    assign P3 = p_q[3];
    assign P4 = p_q[4];
    assign P5 = p_q[5];
    assign P6 = p_q[6];
    assign P7 = p_q[7];

endmodule

// File: tb/tb_booth_pp_gen.sv
// Bench for booth_pp_gen: directed vectors on DPC=1, sweep over DPC=1,2,4,8.
module tb_booth_pp_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid  [4];
    logic        in_ready  [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic        busy      [4];
    logic [15:0] a_i       [4];
    logic [15:0] b_i       [4];
    logic [17:0] pp        [4][8];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        booth_pp_gen #(.DPC(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .A         (a_i[g]),
            .B         (b_i[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .busy      (busy[g]),
            .P0        (pp[g][0]),
            .P1        (pp[g][1]),
            .P2        (pp[g][2]),
            .P3        (pp[g][3]),
            .P4        (pp[g][4]),
            .P5        (pp[g][5]),
            .P6        (pp[g][6]),
            .P7        (pp[g][7])
        );
    end

    int n_chk = 0;
    int n_pass = 0;
    logic [17:0] exp_p [8];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Digit value from its definition: -2*b[2i+1] + b[2i] + b[2i-1].
    function automatic logic [17:0] model_pp(input logic [15:0] b,
                                             input logic [15:0] a, input int i);
        int d;
        int bm;
        bm = (i == 0) ? 0 : int'(b[2*i-1]);
        d = -2 * int'(b[2*i+1]) + int'(b[2*i]) + bm;
        return 18'(d * int'($signed(a)));
    endfunction

    function automatic logic [31:0] tree(input int k);
        logic signed [31:0] s;
        s = 0;
        for (int i = 0; i < 8; i++)
            s = s + (32'(signed'(pp[k][i])) <<< (2 * i));
        return s;
    endfunction

    task automatic run(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp_sum, input int hold,
                       input bit use_exp);
        int t;
        int n;
        t = 0;
        @(negedge clk);
        while (!in_ready[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_idle", in_ready[k], 1);
        in_valid[k] = 1'b1;
        a_i[k] = a;
        b_i[k] = b;
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        a_i[k] = 16'($urandom);
        b_i[k] = 16'($urandom);
        chk("busy_enc", {busy[k], in_ready[k]}, 2'b10);
        n = 0;
        while (!out_valid[k] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'(8 >> k));
        chk("tree_sum", tree(k), exp_sum);
        if (use_exp)
            for (int i = 0; i < 8; i++) chk($sformatf("P%0d", i), pp[k][i], exp_p[i]);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid[k] = 1'b1;
            a_i[k] = 16'($urandom);
            b_i[k] = 16'($urandom);
            @(posedge clk);
            #1;
            chk("hold_flags", {out_valid[k], in_ready[k], busy[k]}, 3'b101);
            chk("hold_sum", tree(k), exp_sum);
            chk("hold_P0", pp[k][0], model_pp(b, a, 0));
        end
        @(negedge clk);
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[k] = 1'b0;
        chk("release", {in_ready[k], out_valid[k], busy[k]}, 3'b100);
    endtask

    logic [15:0] corners [5];

    initial begin
        for (int k = 0; k < 4; k++) begin
            in_valid[k] = 1'b0;
            out_ready[k] = 1'b0;
            a_i[k] = '0;
            b_i[k] = '0;
        end
        corners[0] = 16'h0000;
        corners[1] = 16'h0001;
        corners[2] = 16'hFFFF;
        corners[3] = 16'h7FFF;
        corners[4] = 16'h8000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {in_ready[0], out_valid[0], busy[0]}, 3'b100);
        chk("rst_P0", pp[0][0], 18'h0);
        chk("rst_P7", pp[0][7], 18'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", in_ready[0], 1);

        exp_p = '{18'h00003, 18'h00003, 0, 0, 0, 0, 0, 0};
        run(0, 16'd3, 16'd5, 32'd15, 0, 1);

        exp_p = '{0, 0, 0, 0, 0, 0, 0, 18'h10000};
        run(0, 16'h8000, 16'h8000, 32'h40000000, 0, 1);

        exp_p = '{18'h3FFF9, 0, 0, 0, 0, 0, 0, 0};
        run(0, 16'd7, 16'hFFFF, 32'hFFFFFFF9, 0, 1);

        exp_p = '{18'h3FFF9, 0, 0, 0, 0, 0, 0, 0};
        run(0, 16'd7, 16'hFFFF, 32'hFFFFFFF9, 5, 1);

        // Abort in the third ENC cycle, after some P registers were written.
        @(negedge clk);
        in_valid[0] = 1'b1;
        a_i[0] = 16'd100;
        b_i[0] = 16'h7777;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_flags", {in_ready[0], out_valid[0], busy[0]}, 3'b100);
        for (int i = 0; i < 8; i++) chk($sformatf("abort_P%0d", i), pp[0][i], 18'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 16'hFB2E, 16'd567, 32'hFFF552E2, 0, 0);

        for (int k = 0; k < 4; k++) begin
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    run(k, corners[x], corners[y],
                        32'(signed'(corners[x]) * signed'(corners[y])), 0, 0);
            for (int r = 0; r < 40; r++) begin
                logic [15:0] ra;
                logic [15:0] rb;
                ra = 16'($urandom);
                rb = 16'($urandom);
                for (int i = 0; i < 8; i++) exp_p[i] = model_pp(rb, ra, i);
                run(k, ra, rb, 32'(signed'(ra) * signed'(rb)), (r == 0) ? 2 : 0, 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
